// File: rtl/conv_ctrl.sv
// rtl/conv_ctrl.sv - conv_cal tap sequencer (optional pause input via CONV_CTRL_PAUSE_EN)
module conv_ctrl #(
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int padding       = 0,
  parameter int stride        = 1,
  parameter int acc_latency   = 1
) (
  input  logic        clk_en,
  input  logic        rst_n,
  input  logic        start,
`ifdef CONV_CTRL_PAUSE_EN
  input  logic        pause,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] img_addr,
  output logic        img_pad,
  output logic [7:0]  wei_addr,
  output logic        conv_on,
  output logic        srh_fin,
  output logic        chge_rlt,
  output logic        chge_rlt_q,
  output logic [3:0]  rlt_l,
  output logic [3:0]  rlt_c
);

  localparam int result_width  = (img_width  - weight_width  + 2*padding)/stride + 1;
  localparam int result_height = (img_height - weight_height + 2*padding)/stride + 1;

  generate
    if (result_width > 16 || result_height > 16 || result_width < 1 || result_height < 1) begin : g_bad_size
      $error("conv_ctrl: result map must be 1..16 in each dimension");
    end
    if (acc_latency < 1 || acc_latency > 4) begin : g_bad_lat
      $error("conv_ctrl: acc_latency must be 1..4");
    end
  endgenerate

  localparam logic [3:0] RL_MAX = 4'(result_height - 1);
  localparam logic [3:0] RC_MAX = 4'(result_width - 1);
  localparam logic [7:0] KL_MAX = 8'(weight_height - 1);
  localparam logic [7:0] KC_MAX = 8'(weight_width - 1);
  localparam logic [2:0] FL_MAX = 3'(acc_latency);

  typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  rl, rc;
  logic [7:0]  kl, kc;
  logic [2:0]  fl_cnt;
  logic        hold;
  logic        last_tap;
  logic signed [31:0] row_s, col_s;
  logic        in_img;
  logic [3:0]  l_pipe [acc_latency];
  logic [3:0]  c_pipe [acc_latency];
  logic        q_pipe [acc_latency];

`ifdef CONV_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign last_tap = (rl == RL_MAX) && (rc == RC_MAX) && (kl == KL_MAX) && (kc == KC_MAX);

  // Image coordinate of the current tap, signed so the padding border goes negative
  always_comb begin
    row_s  = $signed(32'(rl)) * stride + $signed(32'(kl)) - padding;
    col_s  = $signed(32'(rc)) * stride + $signed(32'(kc)) - padding;
    in_img = (row_s >= 0) && (row_s < img_height) && (col_s >= 0) && (col_s < img_width);
  end

  // State register
  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and per-state outputs; strobes follow the frozen counters during a pause
  always_comb begin
    state_n  = state;
    busy     = 1'b0;
    done     = 1'b0;
    img_addr = '0;
    img_pad  = 1'b0;
    wei_addr = '0;
    conv_on  = 1'b0;
    srh_fin  = 1'b0;
    chge_rlt = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = CALC;
      end
      CALC: begin
        busy     = 1'b1;
        conv_on  = !hold;
        img_pad  = !in_img;
        img_addr = in_img ? 16'(row_s * img_width + col_s) : 16'd0;
        wei_addr = 8'(kl * 8'(weight_width) + kc);
        srh_fin  = (kl == 8'd0) && (kc == 8'd0) && (rl == 4'd0) && (rc == 4'd0);
        chge_rlt = (kl == 8'd0) && (kc == 8'd0) && !((rl == 4'd0) && (rc == 4'd0));
        if (!hold && last_tap) state_n = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        conv_on = !hold;
        img_pad = 1'b1;
        if (!hold && fl_cnt == FL_MAX) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Tap counters (kc innermost) and flush length counter
  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) begin
      rl <= '0; rc <= '0; kl <= '0; kc <= '0; fl_cnt <= '0;
    end else if (state == IDLE || state == DONE) begin
      rl <= '0; rc <= '0; kl <= '0; kc <= '0; fl_cnt <= '0;
    end else if (state == CALC && !hold) begin
      if (kc == KC_MAX) begin
        kc <= '0;
        if (kl == KL_MAX) begin
          kl <= '0;
          if (rc == RC_MAX) begin
            rc <= '0;
            rl <= (rl == RL_MAX) ? 4'd0 : rl + 4'd1;
          end else begin
            rc <= rc + 4'd1;
          end
        end else begin
          kl <= kl + 8'd1;
        end
      end else begin
        kc <= kc + 8'd1;
      end
    end else if (state == FLUSH && !hold) begin
      fl_cnt <= fl_cnt + 3'd1;
    end
  end

  // Result pointer and reload delay lines; during flush they keep feeding the last window
  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < acc_latency; i++) begin
        l_pipe[i] <= '0;
        c_pipe[i] <= '0;
        q_pipe[i] <= 1'b0;
      end
    end else if (conv_on) begin
      for (int i = acc_latency - 1; i > 0; i--) begin
        l_pipe[i] <= l_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
        q_pipe[i] <= q_pipe[i-1];
      end
      l_pipe[0] <= (state == CALC) ? rl : RL_MAX;
      c_pipe[0] <= (state == CALC) ? rc : RC_MAX;
      q_pipe[0] <= srh_fin | chge_rlt;
    end
  end

  assign rlt_l      = l_pipe[acc_latency-1];
  assign rlt_c      = c_pipe[acc_latency-1];
  assign chge_rlt_q = q_pipe[acc_latency-1];

endmodule

// File: tb/tb_conv_ctrl.sv
// tb/tb_conv_ctrl.sv - directed self-checking bench for conv_ctrl
module tb_conv_ctrl;

  logic        clk_en;
  logic        rst_n;
  logic        start, start1;
  logic        pause, pause1;
  int          n_tests;
  int          n_fail;

  logic        busy, done, img_pad, conv_on, srh_fin, chge_rlt, chge_rlt_q;
  logic [15:0] img_addr;
  logic [7:0]  wei_addr;
  logic [3:0]  rlt_l, rlt_c;

  logic        busy1, done1, img_pad1, conv_on1, srh_fin1, chge_rlt1, chge_rlt_q1;
  logic [15:0] img_addr1;
  logic [7:0]  wei_addr1;
  logic [3:0]  rlt_l1, rlt_c1;

  conv_ctrl u_dut (
    .clk_en(clk_en), .rst_n(rst_n), .start(start),
`ifdef CONV_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy), .done(done), .img_addr(img_addr), .img_pad(img_pad),
    .wei_addr(wei_addr), .conv_on(conv_on), .srh_fin(srh_fin), .chge_rlt(chge_rlt),
    .chge_rlt_q(chge_rlt_q), .rlt_l(rlt_l), .rlt_c(rlt_c)
  );

  conv_ctrl #(.weight_width(3), .weight_height(3), .padding(1)) u_dut_pad (
    .clk_en(clk_en), .rst_n(rst_n), .start(start1),
`ifdef CONV_CTRL_PAUSE_EN
    .pause(pause1),
`endif
    .busy(busy1), .done(done1), .img_addr(img_addr1), .img_pad(img_pad1),
    .wei_addr(wei_addr1), .conv_on(conv_on1), .srh_fin(srh_fin1), .chge_rlt(chge_rlt1),
    .chge_rlt_q(chge_rlt_q1), .rlt_l(rlt_l1), .rlt_c(rlt_c1)
  );

  initial clk_en = 1'b0;
  always #5 clk_en = ~clk_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full default-size map; pause_at >= 0 stalls 3 cycles at that tap
  task automatic run_map(input int pause_at);
    int rl_e, rc_e, kl_e, kc_e, w;
    int prev_l, prev_c, prev_q, srh_n, chg_n, cyc;
    srh_n = 0; chg_n = 0; cyc = 0; prev_l = 0; prev_c = 0; prev_q = 0;
    start = 1'b1;
    @(posedge clk_en); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int t = 0; t < 36; t++) begin
      w    = t / 4;
      rl_e = w / 3;
      rc_e = w % 3;
      kl_e = (t % 4) / 2;
      kc_e = t % 2;
      if (t == pause_at) begin
        pause = 1'b1;
        for (int p = 0; p < 3; p++) begin
          #1;
          check("pause_conv_on", conv_on, 0);
          check("pause_addr", img_addr, (rl_e + kl_e) * 4 + rc_e + kc_e);
          @(posedge clk_en); #1;
          cyc++;
        end
        pause = 1'b0;
        #1;
      end
      check("calc_conv_on", conv_on, 1);
      check("calc_busy", busy, 1);
      check("calc_img_pad", img_pad, 0);
      check("calc_img_addr", img_addr, (rl_e + kl_e) * 4 + rc_e + kc_e);
      check("calc_wei_addr", wei_addr, t % 4);
      check("calc_srh_fin", srh_fin, (t == 0));
      check("calc_chge_rlt", chge_rlt, (t % 4 == 0) && (t != 0));
      check("calc_done", done, 0);
      if (t > 0) begin
        check("calc_rlt_l", rlt_l, prev_l);
        check("calc_rlt_c", rlt_c, prev_c);
        check("calc_chge_rlt_q", chge_rlt_q, prev_q);
      end
      if (t == 20) check("win12_first_addr", img_addr, 6);
      if (t == 23) check("win12_last_addr", img_addr, 11);
      if (t == 21) begin
        check("win12_rlt_l", rlt_l, 1);
        check("win12_rlt_c", rlt_c, 2);
      end
      srh_n += int'(srh_fin);
      chg_n += int'(chge_rlt);
      prev_l = rl_e;
      prev_c = rc_e;
      prev_q = int'(t % 4 == 0);
      @(posedge clk_en); #1;
      cyc++;
    end
    for (int f = 0; f < 2; f++) begin
      check("flush_conv_on", conv_on, 1);
      check("flush_img_pad", img_pad, 1);
      check("flush_addr", {img_addr, wei_addr}, 0);
      check("flush_strobes", {srh_fin, chge_rlt, chge_rlt_q}, 0);
      check("flush_rlt", {rlt_l, rlt_c}, {4'd2, 4'd2});
      check("flush_done", done, 0);
      @(posedge clk_en); #1;
      cyc++;
    end
    check("done_pulse", done, 1);
    check("done_conv_on", conv_on, 0);
    check("done_busy", busy, 1);
    check("done_cycle", cyc, 38 + ((pause_at >= 0) ? 3 : 0));
    check("srh_fin_count", srh_n, 1);
    check("chge_rlt_count", chg_n, 8);
    start = 1'b1;
    @(posedge clk_en); #1;
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    @(posedge clk_en); #1;
    check("start_in_done_ignored", busy, 0);
  endtask

  task automatic run_pad_map();
    int on_n, pad_n, srh_n, chg_n, got_done;
    on_n = 0; pad_n = 0; srh_n = 0; chg_n = 0; got_done = 0;
    start1 = 1'b1;
    @(posedge clk_en); #1;
    start1 = 1'b0;
    for (int i = 0; i < 400 && got_done == 0; i++) begin
      if (i == 0) begin
        check("pad_tap0_img_pad", img_pad1, 1);
        check("pad_tap0_addr", img_addr1, 0);
      end
      if (i == 4) begin
        check("pad_tap4_img_pad", img_pad1, 0);
        check("pad_tap4_addr", img_addr1, 0);
        check("pad_tap4_wei", wei_addr1, 4);
      end
      if (i == 8) check("pad_tap8_addr", img_addr1, 5);
      if (done1) begin
        got_done = 1;
      end else begin
        if (conv_on1) begin
          on_n++;
          pad_n += int'(img_pad1);
        end
        srh_n += int'(srh_fin1);
        chg_n += int'(chge_rlt1);
        @(posedge clk_en); #1;
      end
    end
    check("pad_done_seen", got_done, 1);
    check("pad_conv_on_cycles", on_n, 146);
    check("pad_img_pad_cycles", pad_n, 46);
    check("pad_srh_count", srh_n, 1);
    check("pad_chge_count", chg_n, 15);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    start = 1'b0; start1 = 1'b0; pause = 1'b0; pause1 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ctrl", {busy, done, conv_on, img_pad}, 0);
    check("reset_addr", {img_addr, wei_addr}, 0);
    check("reset_strobes", {srh_fin, chge_rlt, chge_rlt_q}, 0);
    check("reset_rlt", {rlt_l, rlt_c}, 0);
    @(negedge clk_en);
    rst_n = 1'b1;
    @(posedge clk_en); #1;
    check("idle_after_reset", busy, 0);

    run_map(-1);
`ifdef CONV_CTRL_PAUSE_EN
    run_map(10);
`endif

    start = 1'b1;
    @(posedge clk_en); #1;
    start = 1'b0;
    repeat (20) @(posedge clk_en);
    #1;
    check("midrun_tap20_addr", img_addr, 6);
    check("midrun_tap20_rlt", {rlt_l, rlt_c}, {4'd1, 4'd1});
    rst_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", {busy, done, conv_on, img_pad}, 0);
    check("midrun_reset_addr", {img_addr, wei_addr}, 0);
    check("midrun_reset_rlt", {rlt_l, rlt_c, chge_rlt_q}, 0);
    @(negedge clk_en);
    rst_n = 1'b1;
    @(posedge clk_en); #1;
    check("midrun_idle", {busy, done}, 0);
    run_map(-1);

    run_pad_map();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
